rtc_display_latch: RTL
======================

// Module: rtc_display_latch
// PURPOSE
//  Upstream feeder of controlador_VGA. Collects one burst of packed-BCD time/date/timer
//  registers read from the RTC into shadow registers. Optionally converts the 24 h hour
//  to 12 h. Commits the whole set atomically to the display digit outputs on a vsync
//  edge, so a frame never shows a half-updated time.
// PARAMETERS
//  VSYNC_ACTIVE_LOW  1        1: commit on vsync falling edge; 0: on rising edge
//  PENDING_TIMEOUT   2000000  clocks waited in PENDING before forced commit (VGA idle)
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high
//  burst_start      in   1   1-cycle pulse: RTC read burst begins
//  burst_done       in   1   1-cycle pulse: last byte of burst has been presented
//  wr_valid         in   1   reg_addr/reg_data valid this cycle
//  wr_ready         out  1   high only in COLLECT; byte accepted when valid&ready
//  reg_addr         in   4   0 SS,1 MM,2 HH,3 DAY,4 MES,5 YEAR,6 SS_T,7 MM_T,8 HH_T; 9-15 ignored
//  reg_data         in   8   packed BCD, [7:4]=tens (digit1), [3:0]=units (digit0)
//  formato_hora     in   1   0: 24 h, 1: 12 h display
//  timer_en         in   1   timer armed
//  vsync            in   1   vsync from controlador_VGA
//  digit0_*/digit1_* out 4 each  18 display digits: HH,MM,SS,DAY,MES,YEAR,HH_T,MM_T,SS_T
//  AM_PM            out  1   0 AM, 1 PM (meaningful only when formato_hora=1)
//  estado_alarma    out  1   timer_en & committed timer == 00:00:00
//  busy             out  1   state != IDLE
//  bcd_err          out  1   sticky invalid-BCD flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all digits 0, AM_PM 0, estado_alarma 0, busy 0, bcd_err 0, shadow regs 0,
//    state IDLE, vsync history = inactive level, timeout counter 0. Reset mid-burst
//    discards the burst.
//  - FSM IDLE -> COLLECT on burst_start.
//    COLLECT: each valid&ready byte is written to shadow[reg_addr] in the same cycle.
//    COLLECT -> PENDING on burst_done; a byte accepted in that same cycle is kept.
//    PENDING -> COMMIT on the vsync active edge (registered vsync vs. current input),
//    or when the timeout counter reaches PENDING_TIMEOUT-1.
//    COMMIT: copy shadow to the output regs -> IDLE. Outputs are visible the cycle after COMMIT.
//  - Latency: edge sampled in cycle N -> COMMIT in N+1 -> new digits at N+2.
//  - burst_start is ignored outside IDLE. burst_done is ignored outside COLLECT.
//  - burst_start and burst_done in the same IDLE cycle: enter COLLECT only.
//  - The timeout counter runs only in PENDING and clears on leaving it.
//  - Unwritten addresses keep their previous shadow value; partial bursts are legal.
//  - 12 h conversion is applied at COMMIT from shadow HH (24 h BCD):
//    00 -> 12 AM; 01-11 -> same, AM; 12 -> 12 PM; 13-23 -> HH-12, PM.
//    With formato_hora=0, HH passes through and AM_PM = (HH >= 12).
//    Timer digits are never converted.
//  - estado_alarma is registered and recomputed at COMMIT only.
// CONFIGURATION
//  BCD_CHECK_EN defined: a byte with either nibble > 9, or a range violation
//    (HH>23, MM/SS>59, DAY 00 or >31, MES 00 or >12), is rejected. The shadow value is
//    unchanged, and bcd_err sets and holds until reset. A rejected byte still counts as
//    accepted for the handshake.
//  BCD_CHECK_EN undefined: bytes are stored unconditionally; bcd_err tied 0.
// TESTING
//  - reset, then burst HH=0x13 MM=0x45 SS=0x07, formato_hora=1, vsync falling edge
//    -> two clocks after the edge: digit1_HH=0, digit0_HH=1, AM_PM=1, MM=4/5, SS=0/7.
//  - burst done, vsync held high -> digits unchanged until PENDING_TIMEOUT clocks,
//    then committed; busy low the cycle after.
//  - HH=0x00, formato_hora=1 -> HH=1/2, AM_PM=0. Same with formato_hora=0 -> 0/0, AM_PM=0.
//  - timer bytes 0x00,0x00,0x00 with timer_en=1 -> estado_alarma=1 after commit;
//    timer_en=0 and next commit -> 0.
//  - BCD_CHECK_EN: SS byte 0x6A into previous 0x30 -> SS stays 3/0, bcd_err=1.
//    Without the macro: digit1_SS=6, digit0_SS=10, bcd_err=0.
//  - reset asserted in COLLECT after 2 bytes -> all outputs 0, IDLE;
//    a following vsync edge commits nothing.

Source files
------------

// File: rtl/rtc_display_latch.sv
// rtc_display_latch: shadows one RTC register burst and commits it to the display digits on vsync.
// Optional macro BCD_CHECK_EN rejects invalid or out-of-range BCD bytes and raises sticky bcd_err.
module rtc_display_latch #(
    parameter bit          VSYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned PENDING_TIMEOUT  = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       burst_start,
    input  logic       burst_done,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       formato_hora,
    input  logic       timer_en,
    input  logic       vsync,
    output logic [3:0] digit1_HH,
    output logic [3:0] digit0_HH,
    output logic [3:0] digit1_MM,
    output logic [3:0] digit0_MM,
    output logic [3:0] digit1_SS,
    output logic [3:0] digit0_SS,
    output logic [3:0] digit1_DAY,
    output logic [3:0] digit0_DAY,
    output logic [3:0] digit1_MES,
    output logic [3:0] digit0_MES,
    output logic [3:0] digit1_YEAR,
    output logic [3:0] digit0_YEAR,
    output logic [3:0] digit1_HH_T,
    output logic [3:0] digit0_HH_T,
    output logic [3:0] digit1_MM_T,
    output logic [3:0] digit0_MM_T,
    output logic [3:0] digit1_SS_T,
    output logic [3:0] digit0_SS_T,
    output logic       AM_PM,
    output logic       estado_alarma,
    output logic       busy,
    output logic       bcd_err
);

    localparam int unsigned CntW = (PENDING_TIMEOUT > 1) ? $clog2(PENDING_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PENDING_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StPending, StCommit} state_e;

    state_e          state_q, state_d;
    logic            vsync_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      shadow_q [0:8];
    logic [7:0]      hh_q, mm_q, ss_q, day_q, mes_q, year_q, hh_t_q, mm_t_q, ss_t_q;
    logic            am_pm_q, alarma_q, bcd_err_q;

    logic            accept, byte_ok, vsync_edge, timeout_hit, alarm_d;
    logic [7:0]      hh_bin, hh_disp;
    logic [3:0]      hh_sub;
    logic            hh_pm;

    assign wr_ready    = (state_q == StCollect);
    assign accept      = wr_valid && wr_ready;
    assign vsync_edge  = VSYNC_ACTIVE_LOW ? (vsync_q && !vsync) : (!vsync_q && vsync);
    assign timeout_hit = (cnt_q == CntLast);

`ifdef BCD_CHECK_EN
    always_comb begin
        byte_ok = (reg_data[7:4] <= 4'd9) && (reg_data[3:0] <= 4'd9);
        case (reg_addr)
            4'd0, 4'd1, 4'd6, 4'd7: if (reg_data > 8'h59) byte_ok = 1'b0;
            4'd2, 4'd8:             if (reg_data > 8'h23) byte_ok = 1'b0;
            4'd3: if (reg_data == 8'h00 || reg_data > 8'h31) byte_ok = 1'b0;
            4'd4: if (reg_data == 8'h00 || reg_data > 8'h12) byte_ok = 1'b0;
            default: ;
        endcase
    end
`else
    assign byte_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (burst_start) state_d = StCollect;
            StCollect: if (burst_done) state_d = StPending;
            StPending: if (vsync_edge || timeout_hit) state_d = StCommit;
            StCommit:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // 24 h -> 12 h; out-of-range hours are passed through untouched.
    always_comb begin
        hh_bin  = 8'(shadow_q[2][7:4]) * 8'd10 + 8'(shadow_q[2][3:0]);
        hh_sub  = 4'(hh_bin - 8'd12);
        hh_pm   = (hh_bin >= 8'd12);
        hh_disp = shadow_q[2];
        if (formato_hora) begin
            if (hh_bin == 8'd0) begin
                hh_disp = 8'h12;
            end else if (hh_bin >= 8'd13 && hh_bin <= 8'd23) begin
                hh_disp = (hh_sub >= 4'd10) ? {4'd1, hh_sub - 4'd10} : {4'd0, hh_sub};
            end
        end
    end

    assign alarm_d = timer_en && (shadow_q[6] == 8'h00) && (shadow_q[7] == 8'h00)
                     && (shadow_q[8] == 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            vsync_q   <= VSYNC_ACTIVE_LOW;
            cnt_q     <= '0;
            bcd_err_q <= 1'b0;
            for (int i = 0; i < 9; i++) shadow_q[i] <= 8'h00;
            hh_q      <= 8'h00;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            day_q     <= 8'h00;
            mes_q     <= 8'h00;
            year_q    <= 8'h00;
            hh_t_q    <= 8'h00;
            mm_t_q    <= 8'h00;
            ss_t_q    <= 8'h00;
            am_pm_q   <= 1'b0;
            alarma_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            cnt_q   <= (state_q == StPending && state_d == StPending) ? cnt_q + 1'b1 : '0;
            if (accept && reg_addr < 4'd9) begin
                if (byte_ok) shadow_q[reg_addr] <= reg_data;
                else         bcd_err_q          <= 1'b1;
            end
            if (state_q == StCommit) begin
                hh_q     <= hh_disp;
                mm_q     <= shadow_q[1];
                ss_q     <= shadow_q[0];
                day_q    <= shadow_q[3];
                mes_q    <= shadow_q[4];
                year_q   <= shadow_q[5];
                ss_t_q   <= shadow_q[6];
                mm_t_q   <= shadow_q[7];
                hh_t_q   <= shadow_q[8];
                am_pm_q  <= hh_pm;
                alarma_q <= alarm_d;
            end
        end
    end

    assign {digit1_HH,   digit0_HH}   = hh_q;
    assign {digit1_MM,   digit0_MM}   = mm_q;
    assign {digit1_SS,   digit0_SS}   = ss_q;
    assign {digit1_DAY,  digit0_DAY}  = day_q;
    assign {digit1_MES,  digit0_MES}  = mes_q;
    assign {digit1_YEAR, digit0_YEAR} = year_q;
    assign {digit1_HH_T, digit0_HH_T} = hh_t_q;
    assign {digit1_MM_T, digit0_MM_T} = mm_t_q;
    assign {digit1_SS_T, digit0_SS_T} = ss_t_q;
    assign AM_PM         = am_pm_q;
    assign estado_alarma = alarma_q;
    assign busy          = (state_q != StIdle);
    assign bcd_err       = bcd_err_q;

endmodule
